seq_detector_param: RTL and testbench

- Parametrised serial bit-sequence detector for the sequence_detector experiment set; next generation of the fixed single-pattern FSM detectors.
- Runtime-programmable pattern with per-bit don't-care mask, an input valid strobe, and selectable overlapping/non-overlapping detection.
- Registered one-cycle match pulse plus an optional saturating match counter.
- Sits between a serial bit source and a scoring/monitor block.

---
 rtl/seq_detector_param.sv | 156 +++++++++++++++
 tb/tb_seq_detector_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Parametrised serial bit-sequence detector. Valid bits are shifted into a
//   history register. The newest bit enters at hist[0]. A hit occurs when
//   PAT_LEN valid bits have been collected and the masked history equals the
//   masked pattern. The module has overlapping and non-overlapping modes.
//
// Parameters
//   PAT_LEN : pattern length in bits (2..32)
//   CNT_W   : match counter width in bits (>= 1)
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst       in   synchronous, active-high reset
//   in_valid  in   in_bit is sampled on this edge when high
//   in_bit    in   serial data bit
//   pattern   in   target sequence; pattern[PAT_LEN-1] is the oldest bit
//   mask      in   1 = compare this position, 0 = don't care
//   overlap   in   1 = overlapping detection, 0 = non-overlapping
//   clear_cnt in   synchronous clear of match_cnt
//   out       out  registered one-cycle match pulse
//   armed     out  history holds PAT_LEN valid bits
//   match_cnt out  saturating number of matches
//
// Configuration
//   SEQ_DET_MATCH_CNT_EN : when defined, the saturating match counter is
//   built. When undefined, match_cnt is tied to zero and clear_cnt is ignored.
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [PAT_LEN-1:0] mask,
  input  logic               overlap,
  input  logic               clear_cnt,
  output logic               out,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FILL_ONE  = FW'(1'b1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);

  // Logical detector phase. It always agrees with fill_r and is kept as an
  // explicit register so that armed comes straight from a flop.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [PAT_LEN-1:0] hist_r, hist_nx_s;
  logic [FW-1:0]      fill_r, fill_nx_s;
  logic               out_r;
  logic [PAT_LEN-1:0] cand_s;
  logic [FW-1:0]      fill_inc_s;
  logic               hit_s;

  // Masked comparison: only positions with mask=1 take part.
  function automatic logic pattern_hit(input logic [PAT_LEN-1:0] c,
                                       input logic [PAT_LEN-1:0] p,
                                       input logic [PAT_LEN-1:0] m);
    return (((c ^ p) & m) == {PAT_LEN{1'b0}});
  endfunction

  // Next-state logic: shift, fill advance and hit detection.
  always_comb begin
    hist_nx_s  = hist_r;
    fill_nx_s  = fill_r;
    state_nx_s = state_r;
    cand_s     = {hist_r[PAT_LEN-2:0], in_bit};
    fill_inc_s = (fill_r == FILL_FULL) ? FILL_FULL : (fill_r + FILL_ONE);
    hit_s      = 1'b0;
    if (in_valid) begin
      hit_s     = (fill_inc_s == FILL_FULL) && pattern_hit(cand_s, pattern, mask);
      hist_nx_s = cand_s;
      // A non-overlap hit discards the history, so the next match needs
      // PAT_LEN fresh bits.
      if (hit_s && !overlap) begin
        fill_nx_s = FILL_ZERO;
      end else begin
        fill_nx_s = fill_inc_s;
      end
    end else begin
      hist_nx_s = hist_r;
      fill_nx_s = fill_r;
    end
    if (fill_nx_s == FILL_ZERO) begin
      state_nx_s = ST_EMPTY;
    end else if (fill_nx_s == FILL_FULL) begin
      state_nx_s = ST_ARMED;
    end else begin
      state_nx_s = ST_FILLING;
    end
  end

  // State register, history and match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      hist_r  <= {PAT_LEN{1'b0}};
      fill_r  <= FILL_ZERO;
      out_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      hist_r  <= hist_nx_s;
      fill_r  <= fill_nx_s;
      out_r   <= hit_s;
    end
  end

  assign out   = out_r;
  assign armed = (state_r == ST_ARMED);

`ifdef SEQ_DET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r, cnt_nx_s;

  // Saturating counter. A clear that coincides with a hit leaves a count of 1.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (clear_cnt) begin
      cnt_nx_s = hit_s ? CNT_ONE : CNT_ZERO;
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Match counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nx_s;
    end
  end

  assign match_cnt = cnt_r;
`else
  logic unused_clear_cnt_s;
  assign unused_clear_cnt_s = clear_cnt;
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int PAT_LEN = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic [PAT_LEN-1:0] pattern = 4'b1011;
  logic [PAT_LEN-1:0] mask = 4'b1111;
  logic               overlap = 1'b1;
  logic               clear_cnt = 1'b0;
  logic               out_a, armed_a, out_b, armed_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: the valid bits collected since the last restart
  // (reset or non-overlap hit), holding at most PAT_LEN bits.
  bit q[$];
  int m_cnt8 = 0;
  int m_cnt2 = 0;
  logic exp_out;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(PAT_LEN), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .pattern(pattern), .mask(mask), .overlap(overlap), .clear_cnt(clear_cnt),
    .out(out_a), .armed(armed_a), .match_cnt(cnt_a));

  seq_detector_param #(.PAT_LEN(PAT_LEN), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .pattern(pattern), .mask(mask), .overlap(overlap), .clear_cnt(clear_cnt),
    .out(out_b), .armed(armed_b), .match_cnt(cnt_b));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit window_matches();
    for (int i = 0; i < PAT_LEN; i++) begin
      if (mask[i] && (q[q.size()-1-i] != pattern[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive, predict, then sample after the edge.
  task automatic step(input logic r, input logic v, input logic b, input logic clr);
    bit hit;
    int e8, e2;
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; clear_cnt = clr;
    hit = 1'b0;
    if (r) begin
      q.delete();
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (v) begin
        q.push_back(b);
        if (q.size() > PAT_LEN) void'(q.pop_front());
        hit = (q.size() == PAT_LEN) && window_matches();
        if (hit && !overlap) q.delete();
      end
      if (clr) begin
        m_cnt8 = hit ? 1 : 0;
        m_cnt2 = hit ? 1 : 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    exp_out = hit;
`ifdef SEQ_DET_MATCH_CNT_EN
    e8 = m_cnt8; e2 = m_cnt2;
`else
    e8 = 0; e2 = 0;
`endif
    @(posedge clk);
    #1;
    check("out", int'(out_a), int'(exp_out));
    check("armed", int'(armed_a), int'(q.size() == PAT_LEN));
    check("cnt8", int'(cnt_a), e8);
    check("out_w2", int'(out_b), int'(exp_out));
    check("armed_w2", int'(armed_b), int'(q.size() == PAT_LEN));
    check("cnt2", int'(cnt_b), e2);
    if (out_a === 1'b1) pulses++;
  endtask

  task automatic bits(input logic [31:0] seq, input int n, input int idle);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, seq[i], 1'b0);
      for (int k = 0; k < idle; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
  endtask

  initial begin
    logic [31:0] s7;
    logic [31:0] s16;
    s7  = 32'b1011011;
    s16 = 32'b1011011011011011;

    // Reset state
    do_reset();
    check("reset_out", int'(out_a), 0);
    check("reset_armed", int'(armed_a), 0);
    check("reset_cnt", int'(cnt_a), 0);

    // 1: overlapping detection
    pattern = 4'b1011; mask = 4'b1111; overlap = 1'b1;
    bits(s7, 7, 0);
    check("t1_pulses", pulses, 2);

    // 2: non-overlapping detection
    do_reset(); overlap = 1'b0;
    bits(s7, 7, 0);
    check("t2_pulses", pulses, 1);

    // 3: don't-care mask
    do_reset(); overlap = 1'b1; pattern = 4'b1001; mask = 4'b1001;
    bits(32'b11111, 5, 0);
    check("t3_pulses", pulses, 2);

    // 4: idle cycles between valid bits
    do_reset(); pattern = 4'b1011; mask = 4'b1111;
    bits(s7, 7, 2);
    check("t4_pulses", pulses, 2);

    // 5: reset in the middle of a stream
    do_reset();
    bits(32'b101, 3, 0);
    do_reset();
    bits(32'b1011, 4, 0);
    check("t5_pulses", pulses, 1);

    // 6: counter saturation, then clear together with a hit
    do_reset();
    bits(s16, 16, 0);
    check("t6_pulses", pulses, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
`ifdef SEQ_DET_MATCH_CNT_EN
    check("t6_clear_hit", int'(cnt_b), 1);
`else
    check("t6_clear_hit", int'(cnt_b), 0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_clear_only", int'(cnt_a), 0);

    // Random stream with live changes of pattern, mask and overlap
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        pattern = PAT_LEN'($urandom);
        mask    = ($urandom_range(0, 3) == 0) ? 4'b0000 : PAT_LEN'($urandom);
        overlap = 1'($urandom);
      end
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom),
           1'($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
